// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// The cache uses the slave view; the fetch stage and RAM controller together use the master view.
interface icache_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   logic                  flush_i;
   logic                  if_en_i;
   logic [ADDR_WIDTH-1:0] if_addr_i;
   logic                  if_rdy_o;
   logic [INST_WIDTH-1:0] if_inst_o;
   logic                  mem_en_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_rdy_i;
   logic [INST_WIDTH-1:0] mem_inst_i;

   modport slave (
      input  flush_i, if_en_i, if_addr_i, mem_rdy_i, mem_inst_i,
      output if_rdy_o, if_inst_o, mem_en_o, mem_addr_o
   );

   modport master (
      output flush_i, if_en_i, if_addr_i, mem_rdy_i, mem_inst_i,
      input  if_rdy_o, if_inst_o, mem_en_o, mem_addr_o
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer one cycle after
// the request edge; misses hold a word read on the memory port until it returns.
module icache #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INST_WIDTH  = 32,
   parameter int INDEX_WIDTH = 6
) (
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   icache_if.slave  bus
);
   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MISS,
      S_DONE,
      S_ABORT
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_if_rdy, w_if_rdy_nxt;
   logic [INST_WIDTH-1:0]   r_if_inst, w_if_inst_nxt;
   logic                    r_mem_en, w_mem_en_nxt;
   logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic                    w_fill;

   logic [LINES-1:0]        r_valid;
   logic [TAG_W-1:0]        r_tag  [LINES];
   logic [INST_WIDTH-1:0]   r_data [LINES];

   logic [INDEX_WIDTH-1:0]  w_index, w_fill_idx;
   logic [TAG_W-1:0]        w_tag, w_fill_tag;
   logic                    w_hit;
   logic                    w_unused;

   assign w_index    = bus.if_addr_i[INDEX_WIDTH+1:2];
   assign w_tag      = bus.if_addr_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
   // Fill location comes from the held request address, not the live fetch address.
   assign w_fill_idx = r_mem_addr[INDEX_WIDTH+1:2];
   assign w_fill_tag = r_mem_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign w_unused   = ^bus.if_addr_i[1:0];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_if_rdy_nxt   = r_if_rdy;
      w_if_inst_nxt  = r_if_inst;
      w_mem_en_nxt   = r_mem_en;
      w_mem_addr_nxt = r_mem_addr;
      w_fill         = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_if_rdy_nxt = 1'b0;
            if (!bus.flush_i && bus.if_en_i) begin
               if (w_hit) begin
                  w_if_inst_nxt = r_data[w_index];
                  w_if_rdy_nxt  = 1'b1;
                  w_state_nxt   = S_DONE;
               end else begin
                  w_mem_en_nxt   = 1'b1;
                  w_mem_addr_nxt = {bus.if_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  w_state_nxt    = S_MISS;
               end
            end
         end
         S_MISS: begin
            if (bus.mem_rdy_i) begin
               w_fill       = 1'b1;
               w_mem_en_nxt = 1'b0;
               // A redirect on the completion edge still fills but delivers nothing.
               if (bus.flush_i) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_if_inst_nxt = bus.mem_inst_i;
                  w_if_rdy_nxt  = 1'b1;
                  w_state_nxt   = S_DONE;
               end
            end else if (bus.flush_i) begin
               w_state_nxt = S_ABORT;
            end
         end
         S_DONE: begin
            w_if_rdy_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
         end
         S_ABORT: begin
            if (bus.mem_rdy_i) begin
               w_fill       = 1'b1;
               w_mem_en_nxt = 1'b0;
               w_state_nxt  = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= S_IDLE;
         r_if_rdy   <= 1'b0;
         r_if_inst  <= '0;
         r_mem_en   <= 1'b0;
         r_mem_addr <= '0;
         r_valid    <= '0;
      end else if (rdy_in) begin
         r_state    <= w_state_nxt;
         r_if_rdy   <= w_if_rdy_nxt;
         r_if_inst  <= w_if_inst_nxt;
         r_mem_en   <= w_mem_en_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         if (w_fill) r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // NOTE: tag and data arrays are not reset; the valid bits alone make their contents meaningful.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && w_fill) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= bus.mem_inst_i;
      end
   end

   assign bus.if_rdy_o   = r_if_rdy;
   assign bus.if_inst_o  = r_if_inst;
   assign bus.mem_en_o   = r_mem_en;
   assign bus.mem_addr_o = r_mem_addr;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: inputs change and outputs are sampled on the falling edge,
// each step advancing exactly one rising edge.
`timescale 1ns/1ps
module tb_icache;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   icache_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

   icache dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data);
      bus.if_en_i   = 1'b1;
      bus.if_addr_i = addr;
      tick();
      check("hit_rdy",    {31'd0, bus.if_rdy_o}, 32'd1);
      check("hit_inst",   bus.if_inst_o, data);
      check("hit_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
      bus.if_en_i = 1'b0;
      tick();
      check("hit_rdy_drop", {31'd0, bus.if_rdy_o}, 32'd0);
   endtask

   task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data, input int lat);
      bus.if_en_i   = 1'b1;
      bus.if_addr_i = addr;
      tick();
      check("miss_req_en",   {31'd0, bus.mem_en_o}, 32'd1);
      check("miss_req_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
      check("miss_req_rdy",  {31'd0, bus.if_rdy_o}, 32'd0);
      for (int i = 1; i < lat; i++) begin
         tick();
         check("miss_hold_en",   {31'd0, bus.mem_en_o}, 32'd1);
         check("miss_hold_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
      end
      bus.mem_rdy_i  = 1'b1;
      bus.mem_inst_i = data;
      tick();
      bus.mem_rdy_i = 1'b0;
      bus.if_en_i   = 1'b0;
      check("miss_done_rdy",  {31'd0, bus.if_rdy_o}, 32'd1);
      check("miss_done_inst", bus.if_inst_o, data);
      check("miss_done_en",   {31'd0, bus.mem_en_o}, 32'd0);
      tick();
      check("miss_rdy_drop", {31'd0, bus.if_rdy_o}, 32'd0);
   endtask

   initial begin
      bus.flush_i    = 1'b0;
      bus.if_en_i    = 1'b0;
      bus.if_addr_i  = '0;
      bus.mem_rdy_i  = 1'b0;
      bus.mem_inst_i = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_rdy",  {31'd0, bus.if_rdy_o}, 32'd0);
      check("rst_inst", bus.if_inst_o, 32'd0);
      check("rst_en",   {31'd0, bus.mem_en_o}, 32'd0);
      check("rst_addr", bus.mem_addr_o, 32'd0);

      // Cold miss, then hits on the same word with different byte offsets.
      fetch_miss(32'h0000_0000, 32'h0000_0013, 4);
      fetch_hit(32'h0000_0000, 32'h0000_0013);
      fetch_hit(32'h0000_0002, 32'h0000_0013);

      // Same index, different tag: evicts and is evicted.
      fetch_miss(32'h0000_0100, 32'hDEAD_BEEF, 2);
      fetch_hit(32'h0000_0100, 32'hDEAD_BEEF);
      fetch_miss(32'h0000_0000, 32'h0000_0013, 1);

      // Redirect during a miss: request keeps holding, fill still happens, no pulse.
      bus.if_en_i   = 1'b1;
      bus.if_addr_i = 32'h0000_0040;
      tick();
      check("abort_req_en",   {31'd0, bus.mem_en_o}, 32'd1);
      check("abort_req_addr", bus.mem_addr_o, 32'h0000_0040);
      bus.flush_i = 1'b1;
      bus.if_en_i = 1'b0;
      tick();
      bus.flush_i = 1'b0;
      check("abort_hold_en",   {31'd0, bus.mem_en_o}, 32'd1);
      check("abort_hold_addr", bus.mem_addr_o, 32'h0000_0040);
      check("abort_hold_rdy",  {31'd0, bus.if_rdy_o}, 32'd0);
      tick();
      check("abort_wait_en", {31'd0, bus.mem_en_o}, 32'd1);
      bus.mem_rdy_i  = 1'b1;
      bus.mem_inst_i = 32'h1234_5678;
      tick();
      bus.mem_rdy_i = 1'b0;
      check("abort_fill_rdy",  {31'd0, bus.if_rdy_o}, 32'd0);
      check("abort_fill_en",   {31'd0, bus.mem_en_o}, 32'd0);
      check("abort_fill_inst", bus.if_inst_o, 32'h0000_0013);
      tick();
      check("abort_idle_rdy", {31'd0, bus.if_rdy_o}, 32'd0);
      fetch_hit(32'h0000_0040, 32'h1234_5678);

      // Stall mid-miss and with the delivery pulse high.
      bus.if_en_i   = 1'b1;
      bus.if_addr_i = 32'h0000_0080;
      tick();
      check("stall_req_en", {31'd0, bus.mem_en_o}, 32'd1);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_en",   {31'd0, bus.mem_en_o}, 32'd1);
         check("stall_addr", bus.mem_addr_o, 32'h0000_0080);
         check("stall_rdy",  {31'd0, bus.if_rdy_o}, 32'd0);
      end
      rdy = 1'b1;
      tick();
      check("stall_resume_en", {31'd0, bus.mem_en_o}, 32'd1);
      bus.mem_rdy_i  = 1'b1;
      bus.mem_inst_i = 32'hCAFE_F00D;
      tick();
      bus.mem_rdy_i = 1'b0;
      bus.if_en_i   = 1'b0;
      check("stall_done_rdy",  {31'd0, bus.if_rdy_o}, 32'd1);
      check("stall_done_inst", bus.if_inst_o, 32'hCAFE_F00D);
      rdy = 1'b0;
      tick();
      check("stall_pulse_frozen", {31'd0, bus.if_rdy_o}, 32'd1);
      rdy = 1'b1;
      tick();
      check("stall_pulse_drop", {31'd0, bus.if_rdy_o}, 32'd0);
      fetch_hit(32'h0000_0080, 32'hCAFE_F00D);

      // Flush and fetch together in idle: nothing taken, hit or miss.
      bus.flush_i   = 1'b1;
      bus.if_en_i   = 1'b1;
      bus.if_addr_i = 32'h0000_0200;
      tick();
      check("flush_miss_en",  {31'd0, bus.mem_en_o}, 32'd0);
      check("flush_miss_rdy", {31'd0, bus.if_rdy_o}, 32'd0);
      bus.if_addr_i = 32'h0000_0000;
      tick();
      check("flush_hit_rdy", {31'd0, bus.if_rdy_o}, 32'd0);
      bus.flush_i = 1'b0;
      bus.if_en_i = 1'b0;
      tick();

      // Reset during a miss, with the global enable low, wipes the valid bits.
      bus.if_en_i   = 1'b1;
      bus.if_addr_i = 32'h0000_00C0;
      tick();
      check("rstmiss_req_en", {31'd0, bus.mem_en_o}, 32'd1);
      bus.if_en_i = 1'b0;
      rst = 1'b1;
      rdy = 1'b0;
      tick();
      rst = 1'b0;
      rdy = 1'b1;
      check("rstmiss_en",   {31'd0, bus.mem_en_o}, 32'd0);
      check("rstmiss_addr", bus.mem_addr_o, 32'd0);
      check("rstmiss_rdy",  {31'd0, bus.if_rdy_o}, 32'd0);
      check("rstmiss_inst", bus.if_inst_o, 32'd0);
      fetch_miss(32'h0000_0040, 32'h0BAD_F00D, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
